// File: rtl/coherence_bus_ctrl.sv
// Memory/coherence controller: round-robin arbitration of icache/dcache requests onto one RAM port,
// with snooping of coherent dcache misses and cache-to-cache forwarding of dirty lines.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [CPUS-1:0]                iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]    iaddr,
  output logic [CPUS-1:0]                iwait,
  output logic [CPUS-1:0][WORD_W-1:0]    iload,
  input  logic [CPUS-1:0]                dREN,
  input  logic [CPUS-1:0]                dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]    daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]    dstore,
  output logic [CPUS-1:0]                dwait,
  output logic [CPUS-1:0][WORD_W-1:0]    dload,
  input  logic [CPUS-1:0]                cctrans,
  input  logic [CPUS-1:0]                ccwrite,
  output logic [CPUS-1:0]                ccwait,
  output logic [CPUS-1:0]                ccinv,
  output logic [CPUS-1:0][WORD_W-1:0]    ccsnoopaddr,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [WORD_W-1:0]              ramaddr,
  output logic [WORD_W-1:0]              ramstore,
  input  logic [WORD_W-1:0]              ramload,
  input  logic [1:0]                     ramstate
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, SNOOP, SNOOP_RESP, C2C, RAM} state_t;

  state_t          state;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   owner;
  logic [GW-1:0]   ptr;
  logic            src_d;

  logic            found;
  logic [GW-1:0]   pick;
  logic            pick_d;
  logic            own_found;
  logic [GW-1:0]   own_sel;
  logic            acc;

  assign acc = (ramstate == RAM_ACCESS);

  // Round-robin search starting at ptr; dcache wins over icache of the same core.
  always_comb begin
    logic [GW-1:0] idx;
    found  = 1'b0;
    pick   = '0;
    pick_d = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      idx = GW'((32'(ptr) + k) % CPUS);
      if (!found && (dREN[idx] || dWEN[idx] || iREN[idx])) begin
        found  = 1'b1;
        pick   = idx;
        pick_d = dREN[idx] || dWEN[idx];
      end
    end
  end

  always_comb begin
    logic [GW-1:0] jj;
    own_found = 1'b0;
    own_sel   = '0;
    jj        = '0;
    for (int unsigned j = 0; j < CPUS; j++) begin
      jj = GW'(j);
      if (!own_found && (jj != gnt) && ccwrite[jj]) begin
        own_found = 1'b1;
        own_sel   = jj;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      src_d <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt   <= pick;
          src_d <= pick_d;
          state <= (pick_d && cctrans[pick]) ? SNOOP : RAM;
        end
        SNOOP: state <= SNOOP_RESP;
        SNOOP_RESP: begin
          owner <= own_sel;
          state <= own_found ? C2C : RAM;
        end
        C2C, RAM: if (acc) begin
          state <= IDLE;
          ptr   <= (gnt == GW'(CPUS - 1)) ? '0 : gnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and snoop outputs never depend on ramstate, so they live apart from the wait/load logic.
  always_comb begin
    logic [GW-1:0] jj;
    jj          = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (state == SNOOP || state == SNOOP_RESP || state == C2C) begin
      for (int unsigned j = 0; j < CPUS; j++) begin
        jj = GW'(j);
        if (jj != gnt) begin
          ccwait[jj]      = 1'b1;
          ccsnoopaddr[jj] = daddr[gnt];
          ccinv[jj]       = ccwrite[gnt];
        end
      end
    end
    case (state)
      C2C: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[gnt];
        ramstore = dstore[owner];
      end
      RAM: begin
        ramstore = dstore[gnt];
        if (src_d) begin
          ramREN  = dREN[gnt];
          ramWEN  = dWEN[gnt];
          ramaddr = daddr[gnt];
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[gnt];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    case (state)
      C2C: begin
        dload[gnt] = dstore[owner];
        if (acc) begin
          dwait[gnt]   = 1'b0;
          dwait[owner] = 1'b0;
        end
      end
      RAM: if (acc) begin
        if (src_d) begin
          dwait[gnt] = 1'b0;
          dload[gnt] = ramload;
        end else begin
          iwait[gnt] = 1'b0;
          iload[gnt] = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: transaction-timeline model checked every cycle plus directed literal checks.
module tb_coherence_bus_ctrl;
  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [CPUS-1:0]         iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS-1:0][W-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]         iwait, dwait, ccwait, ccinv;
  logic [CPUS-1:0][W-1:0]  iload, dload, ccsnoopaddr;
  logic                    ramREN, ramWEN;
  logic [W-1:0]            ramaddr, ramstore, ramload;
  logic [1:0]              ramstate;

  int n_cmp = 0;
  int n_bad = 0;

  coherence_bus_ctrl #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM: BUSY for lat cycles of strobe, preceded by err_total ERROR cycles, then ACCESS.
  int lat, err_total, cnt, err_seen;
  always_comb begin
    if (!(ramREN || ramWEN))   ramstate = FREE;
    else if (err_seen < err_total) ramstate = ERROR;
    else if (cnt >= lat)       ramstate = ACCESS;
    else                       ramstate = BUSY;
  end
  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramstate == ACCESS) begin
      cnt      <= 0;
      err_seen <= 0;
    end else if (ramstate == ERROR) err_seen <= err_seen + 1;
    else cnt <= cnt + 1;
  end

  // Model: one transaction at a time, described by its age since grant.
  logic [CPUS-1:0]         e_iwait, e_dwait, e_ccwait, e_ccinv;
  logic [CPUS-1:0][W-1:0]  e_iload, e_dload, e_snp;
  logic                    e_ren, e_wen;
  logic [W-1:0]            e_raddr, e_rstore;
  bit m_valid = 0, m_busy = 0, m_d = 0, m_coh = 0;
  int m_cpu = 0, m_age = 0, m_owner = -1, m_ptr = 0;

  always @(negedge CLK) begin : model
    bit data;
    e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
    e_ccwait = '0; e_ccinv = '0; e_snp = '0;
    e_ren = 0; e_wen = 0; e_raddr = '0; e_rstore = '0;
    data = m_busy && (!m_coh || m_age >= 3);
    if (m_busy && m_coh && (m_age <= 2 || m_owner >= 0))
      for (int j = 0; j < CPUS; j++)
        if (j != m_cpu) begin
          e_ccwait[j] = 1'b1;
          e_snp[j]    = daddr[m_cpu];
          e_ccinv[j]  = ccwrite[m_cpu];
        end
    if (data && m_owner >= 0) begin
      e_wen = 1; e_raddr = daddr[m_cpu]; e_rstore = dstore[m_owner];
      e_dload[m_cpu] = dstore[m_owner];
      if (ramstate == ACCESS) begin e_dwait[m_cpu] = 0; e_dwait[m_owner] = 0; end
    end else if (data) begin
      e_rstore = dstore[m_cpu];
      if (m_d) begin
        e_ren = dREN[m_cpu]; e_wen = dWEN[m_cpu]; e_raddr = daddr[m_cpu];
        if (ramstate == ACCESS) begin e_dwait[m_cpu] = 0; e_dload[m_cpu] = ramload; end
      end else begin
        e_ren = 1; e_raddr = iaddr[m_cpu];
        if (ramstate == ACCESS) begin e_iwait[m_cpu] = 0; e_iload[m_cpu] = ramload; end
      end
    end
    if (m_valid) begin
      chk("iwait", iwait, e_iwait);   chk("dwait", dwait, e_dwait);
      chk("iload", iload, e_iload);   chk("dload", dload, e_dload);
      chk("ccwait", ccwait, e_ccwait); chk("ccinv", ccinv, e_ccinv);
      chk("ccsnoopaddr", ccsnoopaddr, e_snp);
      chk("ramREN", ramREN, e_ren);   chk("ramWEN", ramWEN, e_wen);
      chk("ramaddr", ramaddr, e_raddr); chk("ramstore", ramstore, e_rstore);
    end
    if (!nRST) begin
      m_valid = 1; m_busy = 0; m_ptr = 0; m_owner = -1;
    end else if (m_valid) begin
      if (!m_busy) begin
        for (int k = 0; k < CPUS; k++)
          if (!m_busy && (iREN[(m_ptr+k)%CPUS] || dREN[(m_ptr+k)%CPUS] || dWEN[(m_ptr+k)%CPUS])) begin
            m_busy  = 1;
            m_cpu   = (m_ptr + k) % CPUS;
            m_d     = dREN[m_cpu] || dWEN[m_cpu];
            m_coh   = m_d && cctrans[m_cpu];
            m_age   = 1;
            m_owner = -1;
          end
      end else begin
        if (m_coh && m_age == 2)
          for (int j = 0; j < CPUS; j++)
            if (j != m_cpu && ccwrite[j] && m_owner < 0) m_owner = j;
        if (data && ramstate == ACCESS) begin
          m_busy = 0;
          m_ptr  = (m_cpu + 1) % CPUS;
        end else m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  int ord[8];
  int nord;
  task automatic serve(input int n);
    logic [CPUS-1:0] ld, li;
    nord = 0;
    for (int i = 0; i < 8; i++) ord[i] = -1;
    for (int c = 0; c < 100 && nord < n; c++) begin
      @(negedge CLK);
      ld = ~dwait; li = ~iwait;
      for (int k = 0; k < CPUS; k++) begin
        if (ld[k] && nord < 8) begin ord[nord] = k * 2 + 1; nord++; end
        if (li[k] && nord < 8) begin ord[nord] = k * 2;     nord++; end
      end
      @(posedge CLK); #1;
      dREN = dREN & ~ld; dWEN = dWEN & ~ld; iREN = iREN & ~li;
    end
    chk("serve_count", nord, n);
  endtask

  int lows, low_cyc, nerr, done, nsn, nc2c;

  initial begin
    nRST = 0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; lat = 0; err_total = 0;
    tick(); tick(); nRST = 1;
    @(negedge CLK);
    chk("rst_iwait", iwait, 2'b11); chk("rst_dwait", dwait, 2'b11);
    chk("rst_ccwait", ccwait, 0);   chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);   chk("rst_ramaddr", ramaddr, 0);

    // icache fill, RAM latency 2
    tick();
    iREN[0] = 1; iaddr[0] = 32'h40; ramload = 32'hDEADBEEF; lat = 2;
    lows = 0; low_cyc = -1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) chk("t1_ren_c0", ramREN, 0);
      else if (cyc <= 3) begin chk("t1_ren", ramREN, 1); chk("t1_addr", ramaddr, 32'h40); end
      if (!iwait[0]) begin lows++; low_cyc = cyc; chk("t1_iload", iload[0], 32'hDEADBEEF); end
      tick();
      if (low_cyc == cyc) iREN[0] = 0;
    end
    chk("t1_lows", lows, 1); chk("t1_low_cyc", low_cyc, 3);

    // writeback with three ERROR cycles
    dWEN[1] = 1; daddr[1] = 32'h200; dstore[1] = 32'hCAFE; lat = 0; err_total = 3;
    nerr = 0; done = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      if (ramstate == ERROR) begin nerr++; chk("err_dwait", dwait[1], 1); end
      chk("err_nosnoop", ccwait, 0);
      if (!dwait[1]) begin
        chk("err_acc", ramstate, ACCESS); chk("err_store", ramstore, 32'hCAFE); done = cyc;
      end
      tick();
      if (done >= 0) begin dWEN[1] = 0; err_total = 0; break; end
    end
    chk("err_count", nerr, 3); chk("err_done_cyc", done, 4);

    // simultaneous plain reads, pointer at 0
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h104; ramload = 32'h77; lat = 1;
    serve(2);
    chk("burstA_0", ord[0], 1); chk("burstA_1", ord[1], 3);

    // coherent read miss, no owner
    dREN[0] = 1; cctrans[0] = 1; ccwrite = '0; daddr[0] = 32'h80; ramload = 32'h5555; lat = 1;
    nsn = 0; done = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      chk("cohA_ccwait0", ccwait[0], 0);
      if (ccwait[1]) begin
        nsn++; chk("cohA_snpaddr", ccsnoopaddr[1], 32'h80); chk("cohA_ccinv", ccinv[1], 0);
      end
      if (!dwait[0]) begin chk("cohA_dload", dload[0], 32'h5555); done = cyc; end
      tick();
      if (done >= 0) begin dREN[0] = 0; cctrans[0] = 0; break; end
    end
    chk("cohA_snoops", nsn, 2); chk("cohA_done_cyc", done, 4);

    // coherent write miss, CPU1 holds the line dirty
    dREN[0] = 1; cctrans[0] = 1; ccwrite = 2'b11; dstore[1] = 32'h1234; daddr[0] = 32'h80; lat = 1;
    nsn = 0; nc2c = 0; done = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      if (ccwait[1]) begin nsn++; chk("cohB_ccinv", ccinv[1], 1); end
      if (ramWEN) begin
        nc2c++; chk("cohB_store", ramstore, 32'h1234);
        chk("cohB_dload", dload[0], 32'h1234); chk("cohB_addr", ramaddr, 32'h80);
      end
      if (!dwait[0]) begin chk("cohB_owner_dwait", dwait[1], 0); done = cyc; end
      tick();
      if (done >= 0) begin dREN[0] = 0; cctrans[0] = 0; ccwrite = '0; break; end
    end
    chk("cohB_snoops", nsn, 4); chk("cohB_c2c", nc2c, 2); chk("cohB_done_cyc", done, 4);

    // second burst after pointer moved to CPU1; dcache beats icache within CPU1
    dREN = 2'b11; iREN[1] = 1; iaddr[1] = 32'h3C0; lat = 0;
    serve(3);
    chk("burstB_0", ord[0], 3); chk("burstB_1", ord[1], 1); chk("burstB_2", ord[2], 2);

    // reset in the middle of a cache-to-cache transfer
    ccwrite = 2'b10; dstore[1] = 32'h99; dREN[0] = 1; cctrans[0] = 1; daddr[0] = 32'h84; lat = 5;
    tick(); tick(); tick();
    nRST = 0;
    @(negedge CLK);
    chk("rst2_inc2c", ramWEN, 1);
    tick();
    nRST = 1; dREN = '0; cctrans = '0; ccwrite = '0;
    @(negedge CLK);
    chk("rst2_iwait", iwait, 2'b11); chk("rst2_dwait", dwait, 2'b11);
    chk("rst2_ramWEN", ramWEN, 0);   chk("rst2_ccwait", ccwait, 0);
    chk("rst2_ccinv", ccinv, 0);     chk("rst2_ramaddr", ramaddr, 0);

    // fresh request at zero RAM latency
    tick();
    iREN[1] = 1; iaddr[1] = 32'h300; ramload = 32'hABCD; lat = 0;
    done = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      if (!iwait[1]) begin chk("fresh_iload", iload[1], 32'hABCD); done = cyc; end
      tick();
      if (done >= 0) begin iREN[1] = 0; break; end
    end
    chk("fresh_done_cyc", done, 1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
